// File: rtl/pcie_flr_responder.sv
// pcie_flr_responder: queues PCIe FLR requests, holds each function in reset,
// waits for quiescence, then returns a response. Option macro: FLR_TIMEOUT_EN.
module pcie_flr_responder #(
  parameter int FIFO_DEPTH      = 4,
  parameter int RST_HOLD_CYCLES = 16,
  parameter int TIMEOUT_CYCLES  = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flr_req_valid,
  input  logic [2:0]  flr_req_pf,
  input  logic [10:0] flr_req_vf,
  input  logic        flr_req_vf_active,
  output logic        flr_rsp_valid,
  output logic [2:0]  flr_rsp_pf,
  output logic [10:0] flr_rsp_vf,
  output logic        flr_rsp_vf_active,
  output logic        func_rst_valid,
  output logic [2:0]  func_rst_pf,
  output logic [10:0] func_rst_vf,
  output logic        func_rst_vf_active,
  input  logic        func_rst_ack,
  output logic        flr_busy,
  output logic        flr_overflow,
  output logic        flr_timeout,
  input  logic        err_clr
);

  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int MAXC = (RST_HOLD_CYCLES > TIMEOUT_CYCLES) ?
                        RST_HOLD_CYCLES : TIMEOUT_CYCLES;
  localparam int CW   = $clog2(MAXC) + 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ASSERT = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;
  localparam logic [1:0] S_RSP    = 2'd3;

  logic [1:0]    state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [14:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count, count_d;
  logic          full, empty, pop, push, rsp_go;
`ifdef FLR_TIMEOUT_EN
  logic          tmo_hit;
`endif

  assign full    = (count == (AW+1)'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign pop     = (state == S_IDLE) && !empty;
  assign push    = flr_req_valid && (!full || pop);
  assign count_d = count + (AW+1)'(push) - (AW+1)'(pop);
  assign rsp_go  = (state == S_WAIT) && (state_d == S_RSP);

  // Next-state and hold/timeout counter decode
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
`ifdef FLR_TIMEOUT_EN
    tmo_hit = 1'b0;
`endif
    unique case (1'b1)
      (state == S_IDLE): begin
        if (pop) begin
          state_d = S_ASSERT;
          cnt_d   = CW'(RST_HOLD_CYCLES - 1);
        end
      end
      (state == S_ASSERT): begin
        if (cnt == '0) begin
          state_d = S_WAIT;
`ifdef FLR_TIMEOUT_EN
          cnt_d   = CW'(TIMEOUT_CYCLES);
`endif
        end else begin
          cnt_d = cnt - CW'(1);
        end
      end
      (state == S_WAIT): begin
        if (func_rst_ack) begin
          state_d = S_RSP;
        end
`ifdef FLR_TIMEOUT_EN
        else if (cnt <= CW'(1)) begin
          state_d = S_RSP;
          tmo_hit = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt - CW'(1);
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Request queue storage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else if (push) begin
      mem[wr_ptr] <= {flr_req_pf, flr_req_vf, flr_req_vf_active};
    end
  end

  // FSM, queue pointers and busy flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      flr_busy <= 1'b0;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      count    <= count_d;
      flr_busy <= (state_d != S_IDLE) || (count_d != '0);
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
    end
  end

  // Per-function reset and response outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      func_rst_valid     <= 1'b0;
      func_rst_pf        <= '0;
      func_rst_vf        <= '0;
      func_rst_vf_active <= 1'b0;
      flr_rsp_valid      <= 1'b0;
      flr_rsp_pf         <= '0;
      flr_rsp_vf         <= '0;
      flr_rsp_vf_active  <= 1'b0;
    end else begin
      if (pop) begin
        func_rst_valid <= 1'b1;
        {func_rst_pf, func_rst_vf, func_rst_vf_active} <= mem[rd_ptr];
      end else if (rsp_go) begin
        func_rst_valid <= 1'b0;
      end
      flr_rsp_valid <= rsp_go;
      if (rsp_go) begin
        flr_rsp_pf        <= func_rst_pf;
        flr_rsp_vf        <= func_rst_vf;
        flr_rsp_vf_active <= func_rst_vf_active;
      end
    end
  end

  // Sticky overflow flag; clear wins over set
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) flr_overflow <= 1'b0;
    else if (err_clr) flr_overflow <= 1'b0;
    else if (flr_req_valid && !push) flr_overflow <= 1'b1;
  end

`ifdef FLR_TIMEOUT_EN
  // Sticky timeout flag; clear wins over set
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) flr_timeout <= 1'b0;
    else if (err_clr) flr_timeout <= 1'b0;
    else if (tmo_hit) flr_timeout <= 1'b1;
  end
`else
  assign flr_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_pcie_flr_responder.sv
// tb_pcie_flr_responder: scoreboard bench for pcie_flr_responder,
// random traffic plus directed overflow/collision/timeout/reset cases.
module tb_pcie_flr_responder;

  localparam int DEPTH = 4;
  localparam int H     = 16;
  localparam int T     = 8;
`ifdef FLR_TIMEOUT_EN
  localparam int DMAX  = H + T - 1;
`else
  localparam int DMAX  = 30;
`endif

  logic        clk, rst_n;
  logic        flr_req_valid;
  logic [2:0]  flr_req_pf;
  logic [10:0] flr_req_vf;
  logic        flr_req_vf_active;
  logic        flr_rsp_valid;
  logic [2:0]  flr_rsp_pf;
  logic [10:0] flr_rsp_vf;
  logic        flr_rsp_vf_active;
  logic        func_rst_valid;
  logic [2:0]  func_rst_pf;
  logic [10:0] func_rst_vf;
  logic        func_rst_vf_active;
  logic        func_rst_ack;
  logic        flr_busy, flr_overflow, flr_timeout, err_clr;

  pcie_flr_responder #(
    .FIFO_DEPTH(DEPTH),
    .RST_HOLD_CYCLES(H),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .flr_req_valid(flr_req_valid),
    .flr_req_pf(flr_req_pf),
    .flr_req_vf(flr_req_vf),
    .flr_req_vf_active(flr_req_vf_active),
    .flr_rsp_valid(flr_rsp_valid),
    .flr_rsp_pf(flr_rsp_pf),
    .flr_rsp_vf(flr_rsp_vf),
    .flr_rsp_vf_active(flr_rsp_vf_active),
    .func_rst_valid(func_rst_valid),
    .func_rst_pf(func_rst_pf),
    .func_rst_vf(func_rst_vf),
    .func_rst_vf_active(func_rst_vf_active),
    .func_rst_ack(func_rst_ack),
    .flr_busy(flr_busy),
    .flr_overflow(flr_overflow),
    .flr_timeout(flr_timeout),
    .err_clr(err_clr)
  );

  int compared   = 0;
  int mismatched = 0;
  int issued     = 0;
  int rsp_seen   = 0;
  bit hold_low   = 0;
  int fixed_d    = -1;
  logic [14:0] exp_q [$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [14:0] id, input bit expect_it);
    if (expect_it) begin
      exp_q.push_back(id);
      issued++;
    end
    flr_req_valid = 1'b1;
    {flr_req_pf, flr_req_vf, flr_req_vf_active} = id;
    @(negedge clk);
    flr_req_valid = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int b;
    b = 0;
    while ((exp_q.size() != 0 || flr_busy) && b < budget) begin
      @(negedge clk);
      b++;
    end
    check("drain_in_budget", int'(b < budget), 1);
    repeat (3) @(negedge clk);
  endtask

  task automatic pulse_err_clr();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
  endtask

  // Scoreboard monitor: every response must match the oldest expected one
  initial begin : monitor
    logic [14:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && flr_rsp_valid) begin
        rsp_seen++;
        if (exp_q.size() == 0) begin
          check("rsp_unexpected", int'({flr_rsp_pf, flr_rsp_vf,
                flr_rsp_vf_active}), -1);
        end else begin
          e = exp_q.pop_front();
          check("rsp_identity", int'({flr_rsp_pf, flr_rsp_vf,
                flr_rsp_vf_active}), int'(e));
        end
      end
    end
  end

  // Port-logic model: acks d cycles after reset rise, checks pulse shape
  initial begin : ack_model
    int  age, d, exp_w, gap;
    bit  was_hi, seen;
    func_rst_ack = 1'b0;
    age = 0; d = 0; exp_w = 0; gap = 0;
    was_hi = 0; seen = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        func_rst_ack = 1'b0;
        age = 0; was_hi = 0; seen = 0; gap = 0;
      end else if (func_rst_valid) begin
        if (!was_hi) begin
          if (seen) check("rst_gap_ge2", int'(gap >= 2), 1);
          d = (fixed_d >= 0) ? fixed_d : int'($urandom_range(DMAX, 0));
          exp_w = hold_low ? 0 : (((d > H) ? d : H) + 1);
          age = 0;
        end
        func_rst_ack = !hold_low && (age >= d);
        age++;
        was_hi = 1;
      end else begin
        if (was_hi) begin
          if (exp_w > 0) check("rst_width", age, exp_w);
          seen = 1;
          gap = 0;
        end
        gap++;
        func_rst_ack = 1'b0;
        was_hi = 0;
      end
    end
  end

  initial begin : watchdog
    #3ms;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [14:0] id;
    int b, cyc, r0;
    rst_n = 1'b0;
    flr_req_valid = 1'b0;
    flr_req_pf = '0;
    flr_req_vf = '0;
    flr_req_vf_active = 1'b0;
    err_clr = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_rsp", int'({flr_rsp_valid, flr_rsp_pf, flr_rsp_vf,
          flr_rsp_vf_active}), 0);
    check("reset_func", int'({func_rst_valid, func_rst_pf, func_rst_vf,
          func_rst_vf_active}), 0);
    check("reset_flags", int'({flr_busy, flr_overflow, flr_timeout}), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single VF FLR: ack 3 cycles into WAIT_ACK -> 19-cycle reset
    fixed_d = H + 2;
    send({3'd0, 11'd5, 1'b1}, 1);
    check("latency_n1", int'(func_rst_valid), 0);
    @(negedge clk);
    check("latency_n2", int'(func_rst_valid), 1);
    check("func_identity", int'({func_rst_pf, func_rst_vf,
          func_rst_vf_active}), int'({3'd0, 11'd5, 1'b1}));
    wait_drain(200);
    check("busy_after_single", int'(flr_busy), 0);

    // Early ack: ignored in ASSERT -> 17-cycle reset
    fixed_d = 0;
    send(15'($urandom), 1);
    wait_drain(200);

    // Random traffic, never more than 3 outstanding
    fixed_d = -1;
    for (int i = 0; i < 24; i++) begin
      b = 0;
      while ((issued - rsp_seen) > 3 && b < 2000) begin
        @(negedge clk);
        b++;
      end
      if (b >= 2000) check("outstanding_drain", b, 0);
      send(15'($urandom), 1);
      repeat ($urandom_range(3, 0)) @(negedge clk);
    end
    wait_drain(3000);
    check("no_ovf_random", int'(flr_overflow), 0);
    check("no_tmo_random", int'(flr_timeout), 0);

    // Overflow: 1 in service + DEPTH queued, the rest dropped
    hold_low = 1;
    for (int k = 0; k < 6; k++) begin
      id = {3'(k), 11'($urandom), 1'($urandom)};
      send(id, k < DEPTH + 1);
    end
    check("ovf_set", int'(flr_overflow), 1);
    hold_low = 0;
    wait_drain(1000);
    check("ovf_sticky", int'(flr_overflow), 1);
    pulse_err_clr();
    check("ovf_cleared", int'(flr_overflow), 0);
    check("tmo_cleared", int'(flr_timeout), 0);

    // Push into a full queue on the same cycle IDLE pops
    hold_low = 1;
    for (int k = 0; k < DEPTH + 1; k++) send(15'($urandom), 1);
    check("full_no_ovf", int'(flr_overflow), 0);
    hold_low = 0;
    b = 0;
    while (!flr_rsp_valid && b < 200) begin
      @(negedge clk);
      b++;
    end
    check("collide_rsp_seen", int'(b < 200), 1);
    @(posedge clk);
    @(negedge clk);
    send({3'd7, 11'h7ff, 1'b1}, 1);
    check("collide_no_ovf", int'(flr_overflow), 0);
    wait_drain(1000);
    check("collide_no_ovf_end", int'(flr_overflow), 0);
    pulse_err_clr();

    // Ack never returned
    hold_low = 1;
    id = 15'($urandom);
`ifdef FLR_TIMEOUT_EN
    send(id, 1);
    b = 0;
    while (!func_rst_valid && b < 10) begin
      @(negedge clk);
      b++;
    end
    cyc = 0;
    while (!flr_rsp_valid && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check("tmo_rsp_cycle", cyc, H + T);
    check("tmo_flag", int'(flr_timeout), 1);
    hold_low = 0;
    wait_drain(200);
    pulse_err_clr();
    check("tmo_flag_clr", int'(flr_timeout), 0);
`else
    send(id, 0);
    r0 = rsp_seen;
    repeat (10000) @(negedge clk);
    check("no_tmo_rsp", rsp_seen - r0, 0);
    check("no_tmo_flag", int'(flr_timeout), 0);
    check("no_tmo_still_rst", int'(func_rst_valid), 1);
    exp_q.push_back(id);
    issued++;
    hold_low = 0;
    wait_drain(200);
`endif

    // Reset in ASSERT with two requests queued
    hold_low = 1;
    for (int k = 0; k < 3; k++) send(15'($urandom), 0);
    repeat (5) @(negedge clk);
    check("pre_reset_rst", int'(func_rst_valid), 1);
    rst_n = 1'b0;
    #1;
    check("mid_reset_func", int'({func_rst_valid, func_rst_pf, func_rst_vf,
          func_rst_vf_active}), 0);
    check("mid_reset_flags", int'({flr_rsp_valid, flr_busy, flr_overflow,
          flr_timeout}), 0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    hold_low = 0;
    r0 = rsp_seen;
    repeat (100) @(negedge clk);
    check("post_reset_no_rsp", rsp_seen - r0, 0);
    check("post_reset_busy", int'(flr_busy), 0);
    check("post_reset_rst", int'(func_rst_valid), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule

// File: doc/pcie_flr_responder.md
# pcie_flr_responder

FIM-side responder for PCIe Function-Level Reset (FLR). It accepts single-cycle FLR request pulses from the PCIe subsystem and queues them. For each request it drives a per-function reset to the affected port logic and waits for that logic to acknowledge quiescence. It then returns a single-cycle FLR response pulse with the same function identity. It sits between the PCIe subsystem's FLR request/response sideband and the port/AFU reset fabric, which is the counterpart of the host-side FLR manager.

## Interface
- FIFO_DEPTH, 4, request queue depth; power of 2, ≥2
- RST_HOLD_CYCLES, 16, minimum cycles func_rst_valid is held before acks are sampled; ≥1
- TIMEOUT_CYCLES, 4096, WAIT_ACK limit; only used with FLR_TIMEOUT_EN

- clk  in  1  clock for all logic
- rst_n  in  1  asynchronous active-low reset
- flr_req_valid  in  1  one-cycle FLR request strobe; no backpressure
- flr_req_pf  in  3  physical function number
- flr_req_vf  in  11  virtual function number
- flr_req_vf_active  in  1  1 = VF reset, 0 = PF reset
- flr_rsp_valid  out  1  one-cycle FLR completion strobe
- flr_rsp_pf / flr_rsp_vf / flr_rsp_vf_active  out  3/11/1  identity of the completed function
- func_rst_valid  out  1  per-function reset asserted (level)
- func_rst_pf / func_rst_vf / func_rst_vf_active  out  3/11/1  function under reset
- func_rst_ack  in  1  port logic quiesced
- flr_busy  out  1  FSM not in IDLE, or FIFO not empty
- flr_overflow  out  1  sticky: a request was dropped
- flr_timeout  out  1  sticky: an ack timed out (FLR_TIMEOUT_EN only)
- err_clr  in  1  clears both sticky flags

## Operation
- FIFO holds {pf, vf, vf_active}, 15 bits per entry.
- Push on flr_req_valid. A push is accepted when the FIFO is not full, or when a pop occurs in the same cycle.
- When the FIFO is full and no pop occurs, the request is dropped and flr_overflow is set.
- FSM states: IDLE, ASSERT, WAIT_ACK, RSP.
- IDLE: if the FIFO is not empty, pop the head, latch it into the func_rst_* registers, load the hold counter with RST_HOLD_CYCLES-1, and go to ASSERT.
- ASSERT: func_rst_valid=1 and the counter decrements each cycle. At 0, go to WAIT_ACK. func_rst_ack is ignored in this state.
- WAIT_ACK: func_rst_valid=1. When func_rst_ack=1, go to RSP.
- RSP: func_rst_valid=0, flr_rsp_valid=1 for exactly one cycle, flr_rsp_* = latched identity. Next state is IDLE.
- Requests are serviced strictly in arrival order. Duplicate requests for the same function are each serviced.
- err_clr has priority over a same-cycle set, so the flag reads 0 on the next cycle.
- Output register widths are fixed at 3/11/1. Counter width is clog2 of the larger of RST_HOLD_CYCLES and TIMEOUT_CYCLES, plus 1.

## Timing
- Reset values: all outputs 0, FSM=IDLE, FIFO empty, counters 0.
- Reset asserted mid-operation aborts the FSM and empties the FIFO. No response is issued for aborted or queued requests.
- All outputs are registered.
- Request to func_rst_valid rise, starting from IDLE with an empty FIFO: request sampled at edge N, pushed at N, popped at N+1, func_rst_valid=1 from N+2.
- func_rst_valid stays high for at least RST_HOLD_CYCLES+1 cycles (ASSERT plus at least one WAIT_ACK cycle).
- Ack to response: ack sampled high at edge M; flr_rsp_valid=1 and func_rst_valid=0 in cycle M+1.
- Back-to-back: after RSP, the FSM sits in IDLE for one cycle before the next ASSERT. Minimum gap between func_rst_valid pulses is 2 cycles.
- Simultaneous push and pop with FIFO full: both succeed, occupancy unchanged, no overflow.

## Configuration
- FLR_TIMEOUT_EN defined:
  - WAIT_ACK loads a counter with TIMEOUT_CYCLES on entry.
  - If the counter reaches 0 without an ack, flr_timeout is set and the FSM goes to RSP; a response is still issued.
  - An ack in the final counting cycle wins over the timeout; flr_timeout stays 0.
- FLR_TIMEOUT_EN undefined:
  - WAIT_ACK waits indefinitely.
  - flr_timeout is tied to 0 and TIMEOUT_CYCLES is unused.

## Test plan
- Single VF FLR: pf=0, vf=5, vf_active=1, RST_HOLD_CYCLES=16, ack returned 3 cycles after WAIT_ACK entry -> func_rst_valid high for 19 cycles; one flr_rsp_valid pulse with pf=0, vf=5, vf_active=1; flr_busy returns to 0.
- Early ack: func_rst_ack held high from the first ASSERT cycle -> ignored until WAIT_ACK; response in the cycle after WAIT_ACK entry; func_rst_valid high for exactly 17 cycles.
- Ordering and overflow: FIFO_DEPTH=4 and ack held low, 6 back-to-back requests with pf=0..5 -> 5 are held (1 in service, 4 queued), pf=5 is dropped, flr_overflow=1. Release ack -> responses for pf=0..4 in order. err_clr -> flr_overflow=0.
- Full-FIFO push/pop collision: a request arrives in the same cycle IDLE pops from a full FIFO -> accepted, no overflow, serviced last.
- Timeout (FLR_TIMEOUT_EN, TIMEOUT_CYCLES=8): ack never asserted -> flr_timeout=1 and flr_rsp_valid pulses 8 cycles after WAIT_ACK entry. Without the macro -> no response after 10000 cycles, flr_timeout=0.
- Reset mid-operation: rst_n asserted during ASSERT with 2 requests queued -> all outputs 0 immediately; after release no response is produced; flr_busy=0.
